// File: rtl/decode_stage_pipe_if.sv
// Boundary bundle of decode_stage_pipe: IF/ID handshake, write-back port and the registered ID/EX outputs.
// The slave modport is the decode stage itself; master is the surrounding pipeline.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] pc_plus4_i;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_reg_write;
  logic            out_mem_write;
  logic            out_jump;
  logic            out_branch;
  logic            out_alu_src_a;
  logic            out_alu_src_b;
  logic [1:0]      out_result_src;
  logic [3:0]      out_alu_control;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, instr_i, pc_i, pc_plus4_i, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_reg_write, out_mem_write, out_jump, out_branch,
           out_alu_src_a, out_alu_src_b, out_result_src, out_alu_control, out_rs1_data,
           out_rs2_data, out_imm, out_pc, out_pc_plus4, out_rs1, out_rs2, out_rd
  );

  modport slave (
    input  in_valid, instr_i, pc_i, pc_plus4_i, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_reg_write, out_mem_write, out_jump, out_branch,
           out_alu_src_a, out_alu_src_b, out_result_src, out_alu_control, out_rs1_data,
           out_rs2_data, out_imm, out_pc, out_pc_plus4, out_rs1, out_rs2, out_rd
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Pipelined RV decode stage: decode, bypassed register file, XLEN immediates, ID/EX register, load-use bubbles.
// Optional macro DECODE_PERF_CNT_EN adds saturating stall/flush performance counters.
module decode_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic               clk,
  input  logic               rst,
  decode_stage_pipe_if.slave bus
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);
  localparam int         IDXW      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [4:0]      rs1, rs2, rd;
  logic            reg_write, mem_write, jump, branch, alu_src_a, alu_src_b;
  logic [1:0]      result_src, alu_op;
  logic [3:0]      alu_control;
  imm_sel_t        imm_sel;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext, rs1_data, rs2_data;
  logic            hazard, accept;
  logic [XLEN-1:0] regs [REG_COUNT];

  assign instr    = bus.instr_i;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    result_src = 2'b00;
    alu_op     = 2'b00;
    imm_sel    = IMM_NONE;
    case (opcode)
      7'b0000011: begin reg_write = 1'b1; alu_src_b = 1'b1; result_src = 2'b01; imm_sel = IMM_I; end
      7'b0100011: begin mem_write = 1'b1; alu_src_b = 1'b1; imm_sel = IMM_S; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin reg_write = 1'b1; alu_src_b = 1'b1; alu_op = 2'b10; imm_sel = IMM_I; end
      7'b1100011: begin branch = 1'b1; alu_op = 2'b01; imm_sel = IMM_B; end
      7'b1101111: begin reg_write = 1'b1; jump = 1'b1; result_src = 2'b10; imm_sel = IMM_J; end
      7'b1100111: begin reg_write = 1'b1; jump = 1'b1; alu_src_b = 1'b1; result_src = 2'b10; imm_sel = IMM_I; end
      7'b0110111: begin reg_write = 1'b1; alu_src_b = 1'b1; alu_op = 2'b11; imm_sel = IMM_U; end
      7'b0010111: begin reg_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 1'b1; imm_sel = IMM_U; end
      default: ;
    endcase
  end

  // ALU encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass B (lui)
  always_comb begin
    alu_control = 4'd0;
    case (alu_op)
      2'b01: alu_control = 4'd1;
      2'b11: alu_control = 4'd10;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] && funct7b5) ? 4'd1 : 4'd0;
          3'b001:  alu_control = 4'd7;
          3'b010:  alu_control = 4'd5;
          3'b011:  alu_control = 4'd6;
          3'b100:  alu_control = 4'd4;
          3'b101:  alu_control = funct7b5 ? 4'd9 : 4'd8;
          3'b110:  alu_control = 4'd3;
          default: alu_control = 4'd2;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (imm_sel)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    imm_ext        = {XLEN{imm32[31]}};
    imm_ext[31:0]  = imm32;
  end

  // Out-of-range indices read zero even when the same index is being written back.
  always_comb begin
    rs1_data = '0;
    if (rs1 != 5'd0 && {1'b0, rs1} < REG_LIMIT) begin
      if (bus.wb_we && bus.wb_rd == rs1) rs1_data = bus.wb_data;
      else                               rs1_data = regs[rs1[IDXW-1:0]];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2 != 5'd0 && {1'b0, rs2} < REG_LIMIT) begin
      if (bus.wb_we && bus.wb_rd == rs2) rs2_data = bus.wb_data;
      else                               rs2_data = regs[rs2[IDXW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (bus.wb_we && bus.wb_rd != 5'd0 && {1'b0, bus.wb_rd} < REG_LIMIT) begin
      regs[bus.wb_rd[IDXW-1:0]] <= bus.wb_data;
    end
  end

  assign hazard = bus.out_valid && bus.out_result_src == 2'b01 && bus.out_rd != 5'd0 &&
                  (bus.out_rd == rs1 || bus.out_rd == rs2);
  assign bus.in_ready = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // A hazard bubble and a plain drain both reduce to "consumed, nothing new": clear valid, fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid       <= 1'b0;
      bus.out_reg_write   <= 1'b0;
      bus.out_mem_write   <= 1'b0;
      bus.out_jump        <= 1'b0;
      bus.out_branch      <= 1'b0;
      bus.out_alu_src_a   <= 1'b0;
      bus.out_alu_src_b   <= 1'b0;
      bus.out_result_src  <= 2'b00;
      bus.out_alu_control <= 4'd0;
      bus.out_rs1_data    <= '0;
      bus.out_rs2_data    <= '0;
      bus.out_imm         <= '0;
      bus.out_pc          <= '0;
      bus.out_pc_plus4    <= '0;
      bus.out_rs1         <= 5'd0;
      bus.out_rs2         <= 5'd0;
      bus.out_rd          <= 5'd0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid       <= 1'b1;
      bus.out_reg_write   <= reg_write;
      bus.out_mem_write   <= mem_write;
      bus.out_jump        <= jump;
      bus.out_branch      <= branch;
      bus.out_alu_src_a   <= alu_src_a;
      bus.out_alu_src_b   <= alu_src_b;
      bus.out_result_src  <= result_src;
      bus.out_alu_control <= alu_control;
      bus.out_rs1_data    <= rs1_data;
      bus.out_rs2_data    <= rs2_data;
      bus.out_imm         <= imm_ext;
      bus.out_pc          <= bus.pc_i;
      bus.out_pc_plus4    <= bus.pc_plus4_i;
      bus.out_rs1         <= rs1;
      bus.out_rs2         <= rs2;
      bus.out_rd          <= rd;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (bus.in_valid && hazard && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.flush && bus.out_valid && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised successor of the single-cycle decode block. Integrates the instruction decode, a register file with write-back bypass, immediate sign-extension to XLEN, and a registered ID/EX boundary with valid/ready handshake. Adds load-use hazard detection with automatic bubble insertion and a flush input for branch/jump redirect. Sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath width for PC, register data and immediate (32 or 64); immediates sign-extended from bit 31.
REG_COUNT, 32, architectural integer registers (32, or 16 for RV32E); index >= REG_COUNT reads 0 and ignores writes.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction present from IF/ID
in_ready  out  1  stage accepts instruction this cycle
instr_i  in  32  instruction word
pc_i  in  XLEN  instruction PC
pc_plus4_i  in  XLEN  PC+4
wb_we  in  1  write-back enable
wb_rd  in  5  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  kill ID/EX content and incoming instruction
out_valid  out  1  ID/EX register holds valid instruction
out_ready  in  1  execute consumes ID/EX content
out_reg_write, out_mem_write, out_jump, out_branch, out_alu_src_a, out_alu_src_b  out  1 each  registered control bits
out_result_src  out  2  registered result select (2'b01 = load)
out_alu_control  out  4  registered ALU op
out_rs1_data, out_rs2_data, out_imm, out_pc, out_pc_plus4  out  XLEN each  registered operands
out_rs1, out_rs2, out_rd  out  5 each  registered register indices (for forwarding unit)

Behaviour:
- Clock clk, reset rst: one clock; reset synchronous, active-high.
- Reset: out_valid=0, every out_* field=0, all registers=0. rst mid-transfer discards ID/EX content; no partial state survives.
- Decode combinational from instr_i: rs1=[19:15], rs2=[24:20], rd=[11:7]; control via existing control unit, immediate via existing imm_gen, bits above 31 filled with bit 31.
- Register read: index 0 or >= REG_COUNT returns 0. If wb_we && wb_rd==rs && rs!=0, read returns wb_data in the same cycle (write-first bypass).
- Register write: on posedge when wb_we && wb_rd!=0 && wb_rd<REG_COUNT; x0 never written.
- Hazard (combinational): out_valid && out_result_src==2'b01 && out_rd!=0 && (out_rd==rs1 || out_rd==rs2). Conservative; compares both sources regardless of format.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- ID/EX update per cycle, priority order:
  1. flush: out_valid<=0; incoming not accepted.
  2. in_valid && in_ready: load all fields, out_valid<=1. Latency 1 cycle.
  3. hazard && out_ready: out_valid<=0 (bubble); fields hold; instruction retried next cycle.
  4. out_ready && !in_valid: out_valid<=0.
  5. else hold all fields (out_valid && !out_ready stall).
- Write-back in the same cycle as a hazard-free accept is captured via bypass, never stale.
- Bubble never asserts control side effects: out_valid=0 qualifies all out_* fields.

Optional Feature:
DECODE_PERF_CNT_EN: adds outputs perf_stall_cnt[31:0] (cycles with in_valid && hazard) and perf_flush_cnt[31:0] (cycles with flush && out_valid). Both reset to 0 on rst and saturate at 32'hFFFF_FFFF. Without the macro, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, in_ready=1; read of x5 returns 0.
- Basic flow: wb x1=32'h10, then addi x2,x1,4 (32'h00408113) with pc_i=32'h100 -> next cycle out_valid=1, out_rs1_data=32'h10, out_imm=4, out_rd=2, out_pc=32'h100.
- Bypass: same cycle wb_we=1 wb_rd=3 wb_data=32'hABCD and instr reads x3 -> out_rs1_data=32'hABCD; wb_rd=0 write -> x0 stays 0.
- Load-use: lw x5,0(x6), then add x7,x5,x1 with out_ready=1 -> one cycle in_ready=0 and out_valid=0 bubble, then add issues; with DECODE_PERF_CNT_EN, perf_stall_cnt=1.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush=1 -> next cycle out_valid=0, incoming instruction dropped.
- XLEN=64, REG_COUNT=16: addi with imm -1 -> out_imm=64'hFFFF_FFFF_FFFF_FFFF; write to x20 ignored, read of x20 returns 0.
